// File: rtl/counter.sv
// Free-running modulo counter: adds STEP on every clock and wraps past
// MAX_VAL back into the range 0..MAX_VAL. Asynchronous active-low reset
// loads RST_VAL.
module counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned STEP    = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  output logic [WIDTH-1:0] data_o
);

  // One guard bit so that count + STEP cannot overflow before the wrap test.
  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_modulus;
  logic [WIDTH-1:0] w_next;

  // Next-count computation with wrap modulo MAX_VAL + 1.
  always_comb begin
    w_sum     = SUM_W'(r_count) + SUM_W'(STEP);
    w_modulus = SUM_W'(MAX_VAL) + SUM_W'(1);
    w_next    = WIDTH'(w_sum);
    if (w_sum > SUM_W'(MAX_VAL)) begin
      w_next = WIDTH'(w_sum - w_modulus);
    end
  end

  // Count register; reset wins over any coincident clock edge.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= WIDTH'(RST_VAL);
    end else begin
      r_count <= w_next;
    end
  end

  assign data_o = r_count;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: a default instance (mod 16, step 1) and a
// mod-10 step-3 instance run side by side from the same clock and reset.
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_a;
  logic [3:0] data_b;

  int n_tests = 0;
  int n_fail  = 0;

  counter u_dut_a (
    .clock_i (clk),
    .reset_i (rst_n),
    .data_o  (data_a)
  );

  counter #(
    .WIDTH   (4),
    .RST_VAL (0),
    .MAX_VAL (9),
    .STEP    (3)
  ) u_dut_b (
    .clock_i (clk),
    .reset_i (rst_n),
    .data_o  (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  // Per-clock invariant: range check and step-from-previous while out of reset.
  int  prev_a;
  int  prev_b;
  bit  prev_ok = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("range_a", int'(data_a <= 4'd15), 1);
      check("range_b", int'(data_b <= 4'd9), 1);
      if (prev_ok) begin
        check("step_a", int'(data_a), (prev_a + 1) % 16);
        check("step_b", int'(data_b), (prev_b + 3) % 10);
      end
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
    prev_a = int'(data_a);
    prev_b = int'(data_b);
  end

  initial begin
    vec_t vecs[20];
    vecs = '{
      '{1'b1, 4'd1,  4'd3}, '{1'b1, 4'd2,  4'd6}, '{1'b1, 4'd3,  4'd9},
      '{1'b1, 4'd4,  4'd2}, '{1'b1, 4'd5,  4'd5}, '{1'b1, 4'd6,  4'd8},
      '{1'b1, 4'd7,  4'd1}, '{1'b1, 4'd8,  4'd4}, '{1'b1, 4'd9,  4'd7},
      '{1'b1, 4'd10, 4'd0}, '{1'b1, 4'd11, 4'd3}, '{1'b1, 4'd12, 4'd6},
      '{1'b1, 4'd13, 4'd9}, '{1'b1, 4'd14, 4'd2}, '{1'b1, 4'd15, 4'd5},
      '{1'b1, 4'd0,  4'd8}, '{1'b1, 4'd1,  4'd1}, '{1'b1, 4'd2,  4'd4},
      '{1'b1, 4'd3,  4'd7}, '{1'b1, 4'd4,  4'd0}
    };

    // Reset held over several clocks, released between edges.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_a", int'(data_a), 0);
    check("rst_hold_b", int'(data_b), 0);
    rst_n = 1'b1;
    #1;
    check("release_a", int'(data_a), 0);
    check("release_b", int'(data_b), 0);

    // 20 clocks after release: wrap 15->0 on A, 3..7,0 sequence on B.
    for (int i = 0; i < 20; i++) begin
      rst_n = vecs[i].rst;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_a", i), int'(data_a), int'(vecs[i].exp_a));
      check($sformatf("vec%0d_b", i), int'(data_b), int'(vecs[i].exp_b));
      @(negedge clk);
    end

    // Asynchronous reset mid-count while A = 7.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_async_a", int'(data_a), 7);
    check("pre_async_b", int'(data_b), 9);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", int'(data_a), 0);
    check("async_rst_b", int'(data_b), 0);
    @(posedge clk);
    #1;
    check("async_held_a", int'(data_a), 0);
    check("async_held_b", int'(data_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release2_a", int'(data_a), 0);

    // Reset coincident with a rising edge while A = 5: no step to 6.
    repeat (5) @(posedge clk);
    #1;
    check("pre_sync_a", int'(data_a), 5);
    check("pre_sync_b", int'(data_b), 5);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("edge_rst_a", int'(data_a), 0);
    check("edge_rst_b", int'(data_b), 0);
    @(posedge clk);
    #1;
    check("edge_held_a", int'(data_a), 0);

    // First step after the final release.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_a", int'(data_a), 1);
    check("restart_b", int'(data_b), 3);
    @(posedge clk);
    #1;
    check("restart2_a", int'(data_a), 2);
    check("restart2_b", int'(data_b), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and output width in bits; legal range 1..32.
REQ-002 Parameter RST_VAL, default 0, value loaded on reset; must be <= MAX_VAL.
REQ-003 Parameter MAX_VAL, default 2**WIDTH-1, terminal count for counting up; must fit in WIDTH bits.
REQ-004 Parameter STEP, default 1, increment per enabled clock; legal range 1..MAX_VAL.
REQ-005 Port clock_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port data_o, output, WIDTH bits: current count, driven directly from the count register with no combinational path from any input.

Function
REQ-008 The block SHALL hold one WIDTH-bit count register that drives data_o.
REQ-009 While reset_i = 0, the count SHALL equal RST_VAL, independent of clock_i.
REQ-010 When reset_i is deasserted (0 -> 1), the count SHALL hold RST_VAL until the first following rising edge of clock_i.
REQ-011 On each rising clock_i edge with reset_i = 1, the next count SHALL be count + STEP if count + STEP <= MAX_VAL.
REQ-012 If count + STEP > MAX_VAL, the next count SHALL be (count + STEP) - (MAX_VAL + 1), so the count wraps modulo MAX_VAL + 1.
REQ-013 Intermediate sums SHALL be computed at WIDTH+1 bits so that wrap detection does not overflow.
REQ-014 With default parameters the sequence SHALL be 0,1,2,...,15,0,1,... with one increment per clock.
REQ-015 Latency: a change of count SHALL be visible on data_o immediately after the clock edge that causes it, with zero additional cycles.
REQ-016 The count SHALL never take a value greater than MAX_VAL after reset.
REQ-017 The block SHALL have no enable, load, or direction control; it counts on every clock while out of reset.

Reset
REQ-018 Assertion of reset_i SHALL force data_o to RST_VAL asynchronously within the same simulation time step, including mid-count.
REQ-019 Reset assertion that coincides with a rising clock edge SHALL take priority, leaving data_o = RST_VAL.
REQ-020 The first increment after reset release SHALL occur on the first rising edge at which reset_i is sampled 1.
REQ-021 Output data_o before the first reset assertion is unspecified; benches SHALL apply reset before checking values.

Verification
REQ-022 Hold reset_i = 0 for several clocks, then release between edges: data_o = 0 before release, 0 just after release, 1 after the next rising edge, and 2 after the edge after that.
REQ-023 With default parameters, run 20 clocks after reset release: data_o follows 1,2,...,15,0,1,2,3,4, confirming the wrap from 15 to 0.
REQ-024 Assert reset_i = 0 mid-count between clock edges while data_o = 7: data_o becomes 0 immediately, without waiting for a clock edge, and stays 0 while reset is held.
REQ-025 Assert reset_i = 0 coincident with a rising clock edge while data_o = 5: data_o = 0, with no increment to 6.
REQ-026 Configure WIDTH = 4, MAX_VAL = 9, STEP = 3, RST_VAL = 0: data_o sequence after release is 3,6,9,2,5,8,1,4,7,0.
REQ-027 Add a bench assertion on every clock that data_o <= MAX_VAL and that data_o equals (previous value + STEP) mod (MAX_VAL + 1) while reset_i = 1.
